// File: rtl/spu_evt_monitor.sv
// spu_evt_monitor: passive AXI handshake monitor, per-channel event queues
// drained round-robin onto one stream. Optional: SPU_EVT_TIMESTAMP_EN.
module spu_evt_monitor #(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned ID_W        = 8,
    parameter int unsigned EVT_INFO_W  = 32,
    parameter int unsigned SOURCE_ID   = 0,
    parameter int unsigned SRC_W       = 4,
    parameter int unsigned Q_DEPTH     = 4,
    parameter int unsigned BEAT_EVENTS = 0,
    parameter int unsigned DROP_CNT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [4:0]              en_mask_i,
    input  logic                    ar_valid_i,
    input  logic                    ar_ready_i,
    input  logic [ID_W-1:0]         ar_id_i,
    input  logic [ADDR_W-1:0]       ar_addr_i,
    input  logic [7:0]              ar_len_i,
    input  logic                    aw_valid_i,
    input  logic                    aw_ready_i,
    input  logic [ID_W-1:0]         aw_id_i,
    input  logic [ADDR_W-1:0]       aw_addr_i,
    input  logic [7:0]              aw_len_i,
    input  logic                    w_valid_i,
    input  logic                    w_ready_i,
    input  logic                    w_last_i,
    input  logic                    r_valid_i,
    input  logic                    r_ready_i,
    input  logic                    r_last_i,
    input  logic [ID_W-1:0]         r_id_i,
    input  logic [1:0]              r_resp_i,
    input  logic                    b_valid_i,
    input  logic                    b_ready_i,
    input  logic [ID_W-1:0]         b_id_i,
    input  logic [1:0]              b_resp_i,
    output logic                    evt_valid_o,
    input  logic                    evt_ready_i,
    output logic [2:0]              evt_id_o,
    output logic [EVT_INFO_W-1:0]   evt_info_o,
    output logic [SRC_W-1:0]        evt_src_o,
`ifdef SPU_EVT_TIMESTAMP_EN
    output logic [31:0]             evt_ts_o,
`endif
    output logic [5*DROP_CNT_W-1:0] drop_cnt_o,
    input  logic                    drop_clr_i
);
    localparam int unsigned NCH = 5;
    localparam int unsigned PW  = $clog2(Q_DEPTH);
`ifdef SPU_EVT_TIMESTAMP_EN
    localparam int unsigned E_W = EVT_INFO_W + 32;
`else
    localparam int unsigned E_W = EVT_INFO_W;
`endif

    logic [NCH-1:0]        hs;
    logic [NCH-1:0]        fire;
    logic [NCH-1:0]        cand;
    logic [NCH-1:0]        empty;
    logic [NCH-1:0]        full;
    logic [NCH-1:0]        pop;
    logic [NCH-1:0]        push;
    logic [NCH-1:0]        byp;
    logic [NCH-1:0]        drop;
    logic [EVT_INFO_W-1:0] info [NCH];
    logic [E_W-1:0]        in_e [NCH];
    logic [E_W-1:0]        sel [NCH];
    logic [7:0]            w_beat_q;
    logic                  r_ok;
    logic                  w_ok;
    logic [2:0]            ptr_q;
    logic [2:0]            gnt;
    logic [3:0]            idx;
    logic                  gnt_vld;
    logic                  load;
    logic                  take;
    logic                  out_vld_q;
    logic [2:0]            out_id_q;
    logic [E_W-1:0]        out_e_q;
    logic                  unused_ok;

    assign unused_ok = ^{ar_addr_i, aw_addr_i, ar_id_i, aw_id_i};

    assign hs = {b_valid_i & b_ready_i,
                 w_valid_i & w_ready_i,
                 r_valid_i & r_ready_i,
                 aw_valid_i & aw_ready_i,
                 ar_valid_i & ar_ready_i};

    assign r_ok = (BEAT_EVENTS != 0) || r_last_i;
    assign w_ok = (BEAT_EVENTS != 0) || w_last_i;
    assign fire = hs & en_mask_i & {1'b1, w_ok, r_ok, 2'b11};

    assign info[0] = EVT_INFO_W'({ar_len_i,
                                  ar_addr_i[EVT_INFO_W-9:0]});
    assign info[1] = EVT_INFO_W'({aw_len_i,
                                  aw_addr_i[EVT_INFO_W-9:0]});
    assign info[2] = EVT_INFO_W'({r_resp_i, r_id_i});
    assign info[3] = EVT_INFO_W'(w_beat_q);
    assign info[4] = EVT_INFO_W'({b_resp_i, b_id_i});

    // Beat index counts every W handshake, even when W is masked
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_beat_q <= '0;
        end else if (hs[3]) begin
            w_beat_q <= w_last_i ? 8'd0 : w_beat_q + 8'd1;
        end
    end

`ifdef SPU_EVT_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end

    assign evt_ts_o = out_e_q[E_W-1 -: 32];
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [E_W-1:0]        mem [Q_DEPTH];
        logic [PW:0]           wp_q;
        logic [PW:0]           rp_q;
        logic [DROP_CNT_W-1:0] drop_q;

`ifdef SPU_EVT_TIMESTAMP_EN
        assign in_e[c] = {ts_q, info[c]};
`else
        assign in_e[c] = info[c];
`endif
        assign empty[c] = (wp_q == rp_q);
        assign full[c]  = (wp_q[PW] != rp_q[PW]) &&
                          (wp_q[PW-1:0] == rp_q[PW-1:0]);
        // An empty queue lets a same-cycle fire straight through
        assign sel[c]  = empty[c] ? in_e[c] : mem[rp_q[PW-1:0]];
        assign pop[c]  = take && (gnt == 3'(c)) && !empty[c];
        assign byp[c]  = take && (gnt == 3'(c)) && empty[c];
        assign push[c] = fire[c] && !byp[c] && (!full[c] || pop[c]);
        assign drop[c] = fire[c] && full[c] && !pop[c];

        always_ff @(posedge clk_i) begin
            if (push[c]) begin
                mem[wp_q[PW-1:0]] <= in_e[c];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wp_q   <= '0;
                rp_q   <= '0;
                drop_q <= '0;
            end else begin
                if (push[c]) wp_q <= wp_q + (PW+1)'(1);
                if (pop[c])  rp_q <= rp_q + (PW+1)'(1);
                if (drop_clr_i) begin
                    drop_q <= '0;
                end else if (drop[c] && !(&drop_q)) begin
                    drop_q <= drop_q + DROP_CNT_W'(1);
                end
            end
        end

        assign drop_cnt_o[c*DROP_CNT_W +: DROP_CNT_W] = drop_q;
    end

    assign cand = fire | ~empty;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = {1'b0, ptr_q} + 4'(k);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (!gnt_vld && cand[idx[2:0]]) begin
                gnt_vld = 1'b1;
                gnt     = idx[2:0];
            end
        end
    end

    assign load = !out_vld_q || evt_ready_i;
    assign take = load && gnt_vld;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q <= 1'b0;
            out_id_q  <= '0;
            out_e_q   <= '0;
            ptr_q     <= '0;
        end else if (load) begin
            out_vld_q <= gnt_vld;
            out_id_q  <= gnt_vld ? gnt + 3'd1 : 3'd0;
            out_e_q   <= gnt_vld ? sel[gnt] : '0;
            if (gnt_vld) begin
                ptr_q <= (gnt == 3'd4) ? 3'd0 : gnt + 3'd1;
            end
        end
    end

    assign evt_valid_o = out_vld_q;
    assign evt_id_o    = out_id_q;
    assign evt_info_o  = out_e_q[EVT_INFO_W-1:0];
    assign evt_src_o   = SRC_W'(SOURCE_ID);

endmodule

// File: tb/tb_spu_evt_monitor.sv
// tb_spu_evt_monitor: directed and random checks of spu_evt_monitor against
// a queue-level model; instance 0 uses BEAT_EVENTS=0, instance 1 uses 1.
module tb_spu_evt_monitor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  en_mask;
    logic        ar_valid, ar_ready, aw_valid, aw_ready;
    logic [7:0]  ar_id, aw_id, ar_len, aw_len;
    logic [63:0] ar_addr, aw_addr;
    logic        w_valid, w_ready, w_last;
    logic        r_valid, r_ready, r_last;
    logic [7:0]  r_id, b_id;
    logic [1:0]  r_resp, b_resp;
    logic        b_valid, b_ready;
    logic        evt_ready, drop_clr;

    logic [1:0]  ev_v;
    logic [2:0]  ev_id [2];
    logic [31:0] ev_info [2];
    logic [3:0]  ev_src [2];
    logic [79:0] ev_drop [2];
`ifdef SPU_EVT_TIMESTAMP_EN
    logic [31:0] ev_ts [2];
`endif

    logic [63:0] mq [10][$];
    bit          m_vld [2];
    logic [2:0]  m_id [2];
    logic [31:0] m_info [2];
    logic [31:0] m_ts [2];
    int          m_ptr [2];
    int          m_drop [2][5];
    logic [7:0]  m_beat;
    logic [31:0] m_cyc;
    int          tests;
    int          fails;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        spu_evt_monitor #(.BEAT_EVENTS(d)) u_dut (
            .clk_i(clk), .rst_ni(rst_n), .en_mask_i(en_mask),
            .ar_valid_i(ar_valid), .ar_ready_i(ar_ready),
            .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len),
            .aw_valid_i(aw_valid), .aw_ready_i(aw_ready),
            .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len),
            .w_valid_i(w_valid), .w_ready_i(w_ready), .w_last_i(w_last),
            .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
            .r_id_i(r_id), .r_resp_i(r_resp),
            .b_valid_i(b_valid), .b_ready_i(b_ready),
            .b_id_i(b_id), .b_resp_i(b_resp),
            .evt_valid_o(ev_v[d]), .evt_ready_i(evt_ready),
            .evt_id_o(ev_id[d]), .evt_info_o(ev_info[d]),
            .evt_src_o(ev_src[d]),
`ifdef SPU_EVT_TIMESTAMP_EN
            .evt_ts_o(ev_ts[d]),
`endif
            .drop_cnt_o(ev_drop[d]), .drop_clr_i(drop_clr)
        );
    end

    task automatic chk(input string tag, input logic [79:0] obs,
                       input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) mq[i].delete();
        for (int d = 0; d < 2; d++) begin
            m_vld[d] = 0; m_id[d] = 0; m_info[d] = 0; m_ts[d] = 0;
            m_ptr[d] = 0;
            for (int c = 0; c < 5; c++) m_drop[d][c] = 0;
        end
        m_beat = 0;
        m_cyc  = 0;
    endtask

    // One clock edge of the specified behaviour, from the current inputs
    task automatic model_step();
        logic [31:0] inf [5];
        bit          hsk [5];
        hsk[0] = ar_valid && ar_ready;
        hsk[1] = aw_valid && aw_ready;
        hsk[2] = r_valid && r_ready;
        hsk[3] = w_valid && w_ready;
        hsk[4] = b_valid && b_ready;
        inf[0] = {ar_len, ar_addr[23:0]};
        inf[1] = {aw_len, aw_addr[23:0]};
        inf[2] = 32'({r_resp, r_id});
        inf[3] = 32'(m_beat);
        inf[4] = 32'({b_resp, b_id});
        for (int d = 0; d < 2; d++) begin
            bit f [5];
            bit took [5];
            int w;
            for (int c = 0; c < 5; c++) begin
                f[c] = hsk[c] && en_mask[c];
                if (d == 0 && c == 2 && !r_last) f[c] = 0;
                if (d == 0 && c == 3 && !w_last) f[c] = 0;
                took[c] = 0;
            end
            if (!m_vld[d] || evt_ready) begin
                w = -1;
                for (int k = 0; k < 5; k++) begin
                    int c;
                    c = (m_ptr[d] + k) % 5;
                    if (w < 0 && (mq[d*5+c].size() > 0 || f[c])) w = c;
                end
                if (w >= 0) begin
                    logic [63:0] e;
                    if (mq[d*5+w].size() > 0) begin
                        e = mq[d*5+w].pop_front();
                    end else begin
                        e = {m_cyc, inf[w]};
                        took[w] = 1;
                    end
                    m_vld[d] = 1;
                    m_id[d] = 3'(w + 1);
                    m_info[d] = e[31:0];
                    m_ts[d] = e[63:32];
                    m_ptr[d] = (w + 1) % 5;
                end else begin
                    m_vld[d] = 0;
                    m_id[d] = 0;
                end
            end
            for (int c = 0; c < 5; c++) begin
                if (f[c] && !took[c]) begin
                    if (mq[d*5+c].size() < 4)
                        mq[d*5+c].push_back({m_cyc, inf[c]});
                    else if (m_drop[d][c] < 65535)
                        m_drop[d][c]++;
                end
                if (drop_clr) m_drop[d][c] = 0;
            end
        end
        if (hsk[3]) m_beat = w_last ? 8'd0 : m_beat + 8'd1;
        m_cyc = m_cyc + 1;
    endtask

    task automatic check_cycle();
        for (int d = 0; d < 2; d++) begin
            logic [79:0] dexp;
            for (int c = 0; c < 5; c++)
                dexp[c*16 +: 16] = 16'(m_drop[d][c]);
            chk($sformatf("valid%0d", d), 80'(ev_v[d]), 80'(m_vld[d]));
            chk($sformatf("id%0d", d), 80'(ev_id[d]), 80'(m_id[d]));
            if (m_vld[d]) begin
                chk($sformatf("info%0d", d), 80'(ev_info[d]),
                    80'(m_info[d]));
`ifdef SPU_EVT_TIMESTAMP_EN
                chk($sformatf("ts%0d", d), 80'(ev_ts[d]), 80'(m_ts[d]));
`endif
            end
            chk($sformatf("drop%0d", d), ev_drop[d], dexp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic idle();
        ar_valid = 0; aw_valid = 0; w_valid = 0; r_valid = 0;
        b_valid = 0; drop_clr = 0;
    endtask

    task automatic ar_hs(input logic [63:0] a, input logic [7:0] l);
        ar_valid = 1; ar_ready = 1; ar_addr = a; ar_len = l;
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 0;
        idle();
        en_mask = 5'h1F; evt_ready = 1;
        ar_ready = 0; aw_ready = 0; w_ready = 0; r_ready = 0; b_ready = 0;
        ar_id = 0; aw_id = 0; ar_len = 0; aw_len = 0;
        ar_addr = 0; aw_addr = 0; w_last = 0; r_last = 0;
        r_id = 0; b_id = 0; r_resp = 0; b_resp = 0;
        model_reset();
        #1;
        check_cycle();
        chk("src", 80'(ev_src[0]), 80'd0);
        @(negedge clk);
        rst_n = 1;

        // All five channels in one cycle
        ar_hs(64'h20, 8'd1);
        aw_valid = 1; aw_ready = 1; aw_addr = 64'h44; aw_len = 8'd2;
        r_valid = 1; r_ready = 1; r_last = 1; r_id = 8'h5A; r_resp = 2;
        w_valid = 1; w_ready = 1; w_last = 1;
        b_valid = 1; b_ready = 1; b_id = 8'hC3; b_resp = 1;
        cycle();
        chk("five_id1", 80'(ev_id[0]), 80'd1);
        idle();
        for (int i = 2; i <= 5; i++) begin
            cycle();
            chk($sformatf("five_id%0d", i), 80'(ev_id[0]), 80'(i));
        end
        cycle();
        chk("five_end", 80'(ev_v[0]), 80'd0);
        chk("five_nodrop", ev_drop[0], 80'd0);

        // Single AR
        ar_hs(64'h1000_0040, 8'd3);
        cycle();
        chk("ar_valid", 80'(ev_v[0]), 80'd1);
        chk("ar_id", 80'(ev_id[0]), 80'd1);
        chk("ar_info", 80'(ev_info[0]), 80'h0300_0040);
        idle();
        cycle();
        chk("ar_gone", 80'(ev_v[0]), 80'd0);

        // Back-pressure overflow on AR
        evt_ready = 0;
        for (int i = 0; i < 6; i++) begin
            ar_hs(64'(i * 16), 8'd0);
            cycle();
        end
        idle();
        cycle();
        chk("ovf_hold", 80'(ev_info[0]), 80'd0);
        chk("ovf_drop", 80'(ev_drop[0][15:0]), 80'd1);
        evt_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk($sformatf("ovf_order%0d", i), 80'(ev_info[0]),
                80'(i * 16));
        end
        cycle();
        chk("ovf_end", 80'(ev_v[0]), 80'd0);

        // W burst of four beats
        for (int b = 0; b < 4; b++) begin
            w_valid = 1; w_ready = 1; w_last = (b == 3);
            cycle();
            chk($sformatf("wbeat%0d", b), 80'(ev_info[1]), 80'(b));
        end
        chk("wlast_id", 80'(ev_id[0]), 80'd4);
        chk("wlast_info", 80'(ev_info[0]), 80'd3);
        idle();
        cycle();

        // Masked AW, then clear racing a drop
        en_mask = 5'h1D;
        aw_valid = 1; aw_ready = 1; aw_addr = 64'h88;
        cycle();
        chk("mask_noevt", 80'(ev_v[0]), 80'd0);
        chk("mask_drop", ev_drop[0], 80'd1);
        idle();
        en_mask = 5'h1F;
        evt_ready = 0;
        for (int i = 0; i < 6; i++) begin
            ar_hs(64'(i), 8'd0);
            drop_clr = (i == 5);
            cycle();
        end
        chk("clr_race", 80'(ev_drop[0][15:0]), 80'd0);
        idle();
        evt_ready = 1;
        repeat (6) cycle();

        // Asynchronous reset with queued events
        evt_ready = 0;
        ar_hs(64'h10, 8'd0);
        aw_valid = 1; aw_ready = 1;
        r_valid = 1; r_ready = 1; r_last = 1;
        b_valid = 1; b_ready = 1;
        cycle();
        idle();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_cycle();
        chk("rst_valid", 80'(ev_v[0]), 80'd0);
        @(negedge clk);
        rst_n = 1;
        evt_ready = 1;
        repeat (10) cycle();
        ar_hs(64'h30, 8'd0);
        cycle();
        chk("post_rst_id", 80'(ev_id[0]), 80'd1);
`ifdef SPU_EVT_TIMESTAMP_EN
        chk("ts10", 80'(ev_ts[0]), 80'd10);
`endif
        idle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            ar_valid = 1'($urandom); ar_ready = 1'($urandom);
            ar_addr = {$urandom, $urandom}; ar_len = 8'($urandom);
            aw_valid = 1'($urandom); aw_ready = 1'($urandom);
            aw_addr = {$urandom, $urandom}; aw_len = 8'($urandom);
            w_valid = 1'($urandom); w_ready = 1'($urandom);
            w_last = ($urandom_range(0, 3) == 0);
            r_valid = 1'($urandom); r_ready = 1'($urandom);
            r_last = ($urandom_range(0, 3) == 0);
            r_id = 8'($urandom); r_resp = 2'($urandom);
            b_valid = 1'($urandom); b_ready = 1'($urandom);
            b_id = 8'($urandom); b_resp = 2'($urandom);
            evt_ready = ($urandom_range(0, 3) != 0);
            en_mask = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'h1F;
            drop_clr = ($urandom_range(0, 31) == 0);
            cycle();
        end
        idle();
        en_mask = 5'h1F;
        evt_ready = 1;
        repeat (30) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
